// File: rtl/baud_pkg.sv
// Shared register addresses and standard divisor values for the baud generator.
// Divisors assume a 50 MHz clock with 16x oversampling.
package baud_pkg;

    localparam logic [1:0] ADDR_DB_LO = 2'b10;
    localparam logic [1:0] ADDR_DB_HI = 2'b11;

    localparam int DIV_4800  = 651;
    localparam int DIV_9600  = 326;
    localparam int DIV_19200 = 163;
    localparam int DIV_38400 = 81;

    function automatic logic addr_hit(input logic cs, input logic wr,
                                      input logic [1:0] ioaddr, input logic [1:0] addr);
        return cs & wr & (ioaddr == addr);
    endfunction

endpackage

// File: rtl/baud_tick_cnt.sv
// Reloadable down counter: reloads on zero and emits a registered pulse for it.
// A forced load wins over the zero reload and suppresses the pulse.
module baud_tick_cnt #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] reload_val,
    output logic         zero,
    output logic         pulse
);

    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= RST_VAL;
            pulse <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            pulse <= 1'b0;
        end else if (zero) begin
            cnt   <= reload_val;
            pulse <= 1'b1;
        end else begin
            cnt   <= cnt - W'(1);
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/param_baud_gen.sv
// Programmable baud generator: oversample tick (rx_en) and bit tick (tx_en)
// from a two-byte divisor that only takes effect when the high byte is written.
module param_baud_gen
    import baud_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int OS_LOG2 = 4,
    parameter int RST_DIV = 326
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs,
    input  logic             wr,
    input  logic [1:0]       ioaddr,
    input  logic [7:0]       wdata,
    input  logic             rx_sync_clr,
    output logic             rx_en,
    output logic             tx_en,
    output logic [DIV_W-1:0] div_q
);

    localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);

    logic               lo_wr;
    logic               hi_wr;
    logic               load;
    logic               zero;
    logic [7:0]         staging;
    logic [DIV_W-1:0]   new_div;
    logic [DIV_W-1:0]   load_val;
    logic [OS_LOG2-1:0] tick;

    assign lo_wr    = addr_hit(cs, wr, ioaddr, ADDR_DB_LO);
    assign hi_wr    = addr_hit(cs, wr, ioaddr, ADDR_DB_HI);
    assign new_div  = {wdata[DIV_W-9:0], staging};
    // A commit outranks a resync so the counter always restarts on the new divisor.
    assign load     = hi_wr | rx_sync_clr;
    assign load_val = hi_wr ? new_div : div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= RST_DIV_V[7:0];
            div_q   <= RST_DIV_V;
        end else begin
            if (lo_wr) staging <= wdata;
            if (hi_wr) div_q   <= new_div;
        end
    end

    baud_tick_cnt #(
        .W       (DIV_W),
        .RST_VAL (RST_DIV_V)
    ) u_rx_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .reload_val (div_q),
        .zero       (zero),
        .pulse      (rx_en)
    );

    // tx_en fires alongside the rx tick that wraps the oversample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick  <= '0;
            tx_en <= 1'b0;
        end else if (load) begin
            tick  <= '0;
            tx_en <= 1'b0;
        end else if (zero) begin
            tick  <= tick + OS_LOG2'(1);
            tx_en <= &tick;
        end else begin
            tx_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_baud_gen.sv
// Bench for param_baud_gen: expected pulse edge numbers are queued when stimulus
// is applied and compared against observed rx_en/tx_en edges.
module tb_param_baud_gen;
    import baud_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  ioaddr = 2'b00;
    logic [7:0]  wdata = 8'h00;
    logic        rx_sync_clr = 1'b0;
    logic        rx_en;
    logic        tx_en;
    logic [15:0] div_q;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int viol = 0;
    int last_rx = 0;
    logic prev_rx = 1'b0;
    logic prev_tx = 1'b0;
    int exp_rx[$];
    int exp_tx[$];

    param_baud_gen #(.DIV_W(16), .OS_LOG2(4), .RST_DIV(326)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .wr          (wr),
        .ioaddr      (ioaddr),
        .wdata       (wdata),
        .rx_sync_clr (rx_sync_clr),
        .rx_en       (rx_en),
        .tx_en       (tx_en),
        .div_q       (div_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_en && prev_rx && div_q != 16'd0) viol <= viol + 1;
            if (tx_en && prev_tx) viol <= viol + 1;
            prev_rx <= rx_en;
            prev_tx <= tx_en;
        end
    end

    task automatic do_write(input logic we, input logic [1:0] a, input logic [7:0] d,
                            input logic sync, output int e_n);
        @(negedge clk);
        cs = we; wr = we; ioaddr = a; wdata = d; rx_sync_clr = sync;
        @(posedge clk);
        #1;
        e_n = cyc;
        cs = 1'b0; wr = 1'b0; rx_sync_clr = 1'b0;
    endtask

    task automatic wait_pulse(input logic want_tx, output int stamp);
        int n;
        stamp = -1;
        n = 0;
        while (stamp < 0 && n < 6000) begin
            @(negedge clk);
            n++;
            if (want_tx ? tx_en : rx_en) stamp = cyc;
        end
    endtask

    task automatic drain_and_check_rx_tx(input string tag);
        int t, e;
        while (exp_rx.size() > 0) begin
            wait_pulse(1'b0, t);
            e = exp_rx.pop_front();
            vectors++;
            if (t !== e) begin
                $display("FAIL %s rx_edge actual %0d required %0d", tag, t, e);
                miscompares++;
            end
            last_rx = t;
        end
        while (exp_tx.size() > 0) begin
            wait_pulse(1'b1, t);
            e = exp_tx.pop_front();
            vectors++;
            if (t !== e) begin
                $display("FAIL %s tx_edge actual %0d required %0d", tag, t, e);
                miscompares++;
            end
            last_rx = t;
        end
    endtask

    task automatic test_reset;
        int r;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (rx_en !== 1'b0 || tx_en !== 1'b0) begin
            $display("FAIL reset_outputs actual rx=%b tx=%b required 0 0", rx_en, tx_en);
            miscompares++;
        end
        vectors++;
        if (div_q !== 16'd326) begin
            $display("FAIL reset_div actual %0d required 326", div_q);
            miscompares++;
        end
        rst_n = 1'b1;
        r = cyc;
        exp_rx.push_back(r + 327);
        exp_rx.push_back(r + 654);
        exp_tx.push_back(r + 16 * 327);
        drain_and_check_rx_tx("reset");
    endtask

    task automatic test_lo_only;
        int e;
        int base;
        base = last_rx;
        do_write(1'b1, ADDR_DB_LO, 8'h00, 1'b0, e);
        do_write(1'b1, 2'b00, 8'h77, 1'b0, e);
        do_write(1'b1, 2'b01, 8'h99, 1'b0, e);
        vectors++;
        if (div_q !== 16'd326) begin
            $display("FAIL lo_only_div actual %0d required 326", div_q);
            miscompares++;
        end
        exp_rx.push_back(base + 327);
        exp_rx.push_back(base + 654);
        drain_and_check_rx_tx("lo_only");
    endtask

    task automatic test_commit_81;
        int e, c;
        do_write(1'b1, ADDR_DB_LO, 8'h51, 1'b0, e);
        do_write(1'b1, 2'b01, 8'h99, 1'b0, e);
        vectors++;
        if (div_q !== 16'd326) begin
            $display("FAIL staged_div actual %0d required 326", div_q);
            miscompares++;
        end
        do_write(1'b1, ADDR_DB_HI, 8'h00, 1'b0, c);
        vectors++;
        if (div_q !== 16'(DIV_38400)) begin
            $display("FAIL commit_div actual %0d required %0d", div_q, DIV_38400);
            miscompares++;
        end
        exp_rx.push_back(c + 82);
        exp_rx.push_back(c + 164);
        exp_tx.push_back(c + 1312);
        drain_and_check_rx_tx("div81");
    endtask

    task automatic test_div_zero;
        int e, c;
        do_write(1'b1, ADDR_DB_LO, 8'h00, 1'b0, e);
        do_write(1'b1, ADDR_DB_HI, 8'h00, 1'b0, c);
        vectors++;
        if (div_q !== 16'd0) begin
            $display("FAIL zero_div actual %0d required 0", div_q);
            miscompares++;
        end
        exp_rx.push_back(c + 1);
        exp_rx.push_back(c + 2);
        exp_rx.push_back(c + 3);
        exp_tx.push_back(c + 16);
        exp_tx.push_back(c + 32);
        drain_and_check_rx_tx("div0");
        do_write(1'b1, ADDR_DB_LO, 8'h46, 1'b0, e);
        do_write(1'b1, ADDR_DB_HI, 8'h01, 1'b0, c);
        vectors++;
        if (div_q !== 16'(DIV_9600)) begin
            $display("FAIL restore_div actual %0d required %0d", div_q, DIV_9600);
            miscompares++;
        end
        exp_rx.push_back(c + 327);
        drain_and_check_rx_tx("restore");
    endtask

    task automatic test_sync_clr;
        int e, s, c;
        repeat (99) @(negedge clk);
        do_write(1'b0, 2'b00, 8'h00, 1'b1, s);
        exp_rx.push_back(s + 327);
        exp_tx.push_back(s + 16 * 327);
        drain_and_check_rx_tx("sync");
        do_write(1'b1, ADDR_DB_LO, 8'h51, 1'b0, e);
        repeat (20) @(negedge clk);
        do_write(1'b1, ADDR_DB_HI, 8'h00, 1'b1, c);
        vectors++;
        if (div_q !== 16'd81) begin
            $display("FAIL sync_commit_div actual %0d required 81", div_q);
            miscompares++;
        end
        exp_rx.push_back(c + 82);
        exp_rx.push_back(c + 164);
        drain_and_check_rx_tx("sync_commit");
    endtask

    task automatic test_reset_mid;
        int t, r;
        wait_pulse(1'b0, t);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rx_en !== 1'b0 || tx_en !== 1'b0) begin
            $display("FAIL async_reset_out actual rx=%b tx=%b required 0 0", rx_en, tx_en);
            miscompares++;
        end
        vectors++;
        if (div_q !== 16'd326) begin
            $display("FAIL async_reset_div actual %0d required 326", div_q);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        exp_rx.push_back(r + 327);
        drain_and_check_rx_tx("post_reset");
        vectors++;
        if (div_q !== 16'd326) begin
            $display("FAIL post_reset_div actual %0d required 326", div_q);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_lo_only();
        test_commit_81();
        test_div_zero();
        test_sync_clr();
        test_reset_mid();
        @(negedge clk);
        vectors++;
        if (viol !== 0) begin
            $display("FAIL back_to_back_pulses actual %0d required 0", viol);
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
